// File: rtl/spi_master_frame.sv
// rtl/spi_master_frame.sv - mode-0 SPI master sending 1..2^NUM_WORDS_W words per CS frame.
// Optional receive path enabled by defining SPI_MASTER_RX_EN.
module spi_master_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLK_DIV_HALF = 4,
    parameter int NUM_WORDS_W  = 2,
    parameter int LSB_FIRST    = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [NUM_WORDS_W-1:0] i_words,
    input  logic [DATA_WIDTH-1:0]  i_data_in,
    output logic                   o_data_req,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_cs,
    output logic                   o_s_clk,
    output logic                   o_s_out
`ifdef SPI_MASTER_RX_EN
    ,
    input  logic                   i_s_in,
    output logic [DATA_WIDTH-1:0]  o_rx_data,
    output logic                   o_rx_valid
`endif
);

    localparam int DIV_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GUARD
    } state_t;

    state_t                 r_state;
    logic [DIV_W-1:0]       r_div;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [NUM_WORDS_W-1:0] r_word_cnt;
    logic [NUM_WORDS_W-1:0] r_words;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_cs;
    logic                   r_s_clk;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_data_req;
`ifdef SPI_MASTER_RX_EN
    logic [DATA_WIDTH-1:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
`endif

    logic w_tick;
    logic w_word_end;

    assign w_tick     = (r_state != S_IDLE) && (r_div == DIV_W'(CLK_DIV_HALF - 1));
    assign w_word_end = (r_bit_cnt == BIT_W'(DATA_WIDTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_words    <= '0;
            r_shift    <= '0;
            r_cs       <= 1'b1;
            r_s_clk    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data_req <= 1'b0;
`ifdef SPI_MASTER_RX_EN
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_data_req <= 1'b0;
`ifdef SPI_MASTER_RX_EN
            r_rx_valid <= 1'b0;
`endif
            if (r_state != S_IDLE) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_words    <= i_words;
                        r_word_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_shift    <= i_data_in;
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_div      <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_tick) begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        if (!r_s_clk) begin
                            r_s_clk   <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
`ifdef SPI_MASTER_RX_EN
                            if (LSB_FIRST != 0) begin
                                r_rx_shift <= {i_s_in, r_rx_shift[DATA_WIDTH-1:1]};
                            end else begin
                                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], i_s_in};
                            end
`endif
                        end else begin
                            r_s_clk <= 1'b0;
                            if (w_word_end) begin
`ifdef SPI_MASTER_RX_EN
                                r_rx_data  <= r_rx_shift;
                                r_rx_valid <= 1'b1;
`endif
                                if (r_word_cnt == r_words) begin
                                    // Clearing here parks S_OUT low for HOLD/GUARD/IDLE.
                                    r_shift <= '0;
                                    r_state <= S_HOLD;
                                end else begin
                                    r_shift    <= i_data_in;
                                    r_bit_cnt  <= '0;
                                    r_word_cnt <= r_word_cnt + NUM_WORDS_W'(1);
                                    r_data_req <= 1'b1;
                                end
                            end else if (LSB_FIRST != 0) begin
                                r_shift <= r_shift >> 1;
                            end else begin
                                r_shift <= r_shift << 1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_cs    <= 1'b1;
                        r_state <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (w_tick) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cs       = r_cs;
    assign o_s_clk    = r_s_clk;
    assign o_s_out    = (LSB_FIRST != 0) ? r_shift[0] : r_shift[DATA_WIDTH-1];
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_data_req = r_data_req;
`ifdef SPI_MASTER_RX_EN
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
`endif

endmodule
